// File: rtl/queue_pkt_arbiter.sv
// queue_pkt_arbiter: packet-level round-robin N:1 arbiter feeding one AXI-stream packet queue,
// aborting stalled packets; define QARB_PKT_STATS_EN to add per-source packet/drop counters.
module queue_pkt_arbiter #(
  parameter int N_PORTS = 4,
  parameter int DW      = 8,
  parameter int MW      = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic [N_PORTS-1:0]         s_axis_tvalid,
  input  logic [N_PORTS*DW-1:0]      s_axis_tdata,
  input  logic [N_PORTS-1:0]         s_axis_tlast,
  input  logic [N_PORTS*MW-1:0]      s_axis_tuser_mty,
  output logic [N_PORTS-1:0]         s_axis_tready,
  output logic                       m_axis_tvalid,
  output logic [DW-1:0]              m_axis_tdata,
  output logic                       m_axis_tlast,
  output logic [MW-1:0]              m_axis_tuser_mty,
  input  logic                       m_axis_tready,
  output logic                       drop_incmpt_pkt,
  output logic [$clog2(N_PORTS)-1:0] grant_id,
  output logic                       busy
`ifdef QARB_PKT_STATS_EN
  ,
  output logic [N_PORTS*32-1:0]      pkt_cnt,
  output logic [N_PORTS*16-1:0]      drop_cnt
`endif
);
  localparam int GW = $clog2(N_PORTS);
  localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
  typedef enum logic {IDLE, STREAM} state_t;
  state_t             state_q, state_d;
  logic [GW-1:0]      grant_q, grant_d, cand;
  logic [N_PORTS-1:0] discard_q, discard_d, eligible;
  logic [CW-1:0]      idle_cnt_q, idle_cnt_d;
  logic               drop_q, drop_d, found;
  logic               g_valid, g_last, fwd_hs, timeout;
  assign eligible = s_axis_tvalid & ~discard_q;
  assign g_valid  = s_axis_tvalid[grant_q];
  assign g_last   = s_axis_tlast[grant_q];
  assign fwd_hs   = state_q == STREAM && g_valid && m_axis_tready;
  // the stall abort fires only while streaming with the granted source silent for TIMEOUT cycles
  assign timeout  = TIMEOUT != 0 && state_q == STREAM && !g_valid && idle_cnt_q == TO_LAST;
  // state register; reset mid-packet clears everything without a drop pulse
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= IDLE;
      grant_q    <= GW'(N_PORTS - 1);
      discard_q  <= '0;
      idle_cnt_q <= '0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      discard_q  <= discard_d;
      idle_cnt_q <= idle_cnt_d;
      drop_q     <= drop_d;
    end
  end
  // next state: round-robin pick in IDLE, packet end or stall abort in STREAM
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    idle_cnt_d = idle_cnt_q;
    drop_d     = 1'b0;
    found      = 1'b0;
    cand       = '0;
    discard_d  = discard_q & ~(s_axis_tvalid & s_axis_tlast);
    if (state_q == IDLE) begin
      for (int k = 1; k <= N_PORTS; k++) begin
        cand = GW'((int'(grant_q) + k) % N_PORTS);
        if (!found && eligible[cand]) begin
          found   = 1'b1;
          grant_d = cand;
        end
      end
      state_d = found ? STREAM : IDLE;
    end else if (timeout) begin
      state_d            = IDLE;
      drop_d             = 1'b1;
      idle_cnt_d         = '0;
      discard_d[grant_q] = 1'b1;
    end else begin
      idle_cnt_d = (g_valid || TIMEOUT == 0) ? '0 : idle_cnt_q + 1'b1;
      state_d    = (fwd_hs && g_last) ? IDLE : STREAM;
    end
  end
  // outputs: pass-through from the granted source, discarding sources always ready
  always_comb begin
    busy             = state_q == STREAM;
    m_axis_tvalid    = busy && g_valid;
    m_axis_tdata     = s_axis_tdata[grant_q*DW +: DW];
    m_axis_tlast     = g_last;
    m_axis_tuser_mty = s_axis_tuser_mty[grant_q*MW +: MW];
    s_axis_tready    = discard_q;
    if (busy) s_axis_tready[grant_q] = m_axis_tready;
    drop_incmpt_pkt  = drop_q;
    grant_id         = grant_q;
  end
`ifdef QARB_PKT_STATS_EN
  logic [N_PORTS*32-1:0] pkt_cnt_q;
  logic [N_PORTS*16-1:0] drop_cnt_q;
  // per-source completed-packet and abort counters, free-running with wrap
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      pkt_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (fwd_hs && g_last) pkt_cnt_q[grant_q*32 +: 32] <= pkt_cnt_q[grant_q*32 +: 32] + 32'd1;
      if (drop_d) drop_cnt_q[grant_q*16 +: 16] <= drop_cnt_q[grant_q*16 +: 16] + 16'd1;
    end
  end
  assign pkt_cnt  = pkt_cnt_q;
  assign drop_cnt = drop_cnt_q;
`endif
endmodule
